// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [ADDR_W_DEF-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem handshake and IF/ID outputs.
interface pc_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              imem_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [ADDR_W-1:0] pc;
  logic              if_valid;
  logic              misalign_err;

  modport master (
    output stall, redirect_valid, redirect_target, imem_ready,
    input  imem_req, imem_addr, pc, if_valid, misalign_err
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_ready,
    output imem_req, imem_addr, pc, if_valid, misalign_err
  );

endinterface

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
// Holds one pending redirect target; a newer load overwrites, a fire clears.
module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target_in,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_target
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (clear) begin
      pend_valid  <= 1'b0;
    end else if (load) begin
      pend_valid  <= 1'b1;
      pend_target <= target_in;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, merges stall with ID redirects, buffers late redirects.
// Build option DELAY_SLOT_EN keeps the fetch that accompanies a redirect (MIPS delay slot).
import cpu_pkg::*;

module pc_fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  pc_fetch_ctrl_if.slave bus
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [ADDR_W-1:0] tgt_aligned;
  logic [ADDR_W-1:0] pend_target;
  logic              pend_valid;
  logic              req_c;
  logic              fire_c;
  logic              misalign_q;

  // Request is level while not booting; held low during reset.
  assign req_c       = (state != BOOT) & ~reset;
  assign fire_c      = req_c & bus.imem_ready & ~bus.stall;
  assign tgt_aligned = bus.redirect_target & ADDR_W'(ALIGN_MASK);

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (bus.redirect_valid & ~fire_c),
    .clear       (fire_c),
    .target_in   (tgt_aligned),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      BOOT:     state_nxt = RUN;
      RUN,
      PEND: begin
        if (fire_c)                  state_nxt = RUN;
        else if (bus.redirect_valid) state_nxt = PEND;
      end
      default:  state_nxt = BOOT;
    endcase
    // A live redirect beats a buffered one; otherwise sequential fetch.
    if (fire_c) begin
      if (bus.redirect_valid) pc_nxt = tgt_aligned;
      else if (pend_valid)    pc_nxt = pend_target;
      else                    pc_nxt = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      misalign_q <= bus.redirect_valid & (bus.redirect_target[1:0] != 2'b00);
    end
  end

  assign bus.imem_req     = req_c;
  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.misalign_err = misalign_q;

`ifdef DELAY_SLOT_EN
  assign bus.if_valid = fire_c;
`else
  assign bus.if_valid = fire_c & ~bus.redirect_valid & ~pend_valid;
`endif

endmodule
